// File: rtl/synth_cmd_parser_if.sv
// Command FIFO and readback echo bus between the synth command parser and the CPU stream.
// The parser side takes the master modport; the FIFO/readback side takes the slave modport.
interface synth_cmd_parser_if;
    localparam int unsigned WORD_W = 32;

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_dout;
    logic              echo_wr_en;
    logic [WORD_W-1:0] echo_data;
    logic              echo_full;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  echo_full,
        output fifo_rd_en,
        output echo_wr_en,
        output echo_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output echo_full,
        input  fifo_rd_en,
        input  echo_wr_en,
        input  echo_data
    );
endinterface

// File: rtl/synth_cmd_parser.sv
// Decodes CPU command words into tone period, note pulses and mute for the synth voice.
// Define SYNTH_CMD_ECHO_EN to echo every executed word to the readback FIFO.
module synth_cmd_parser #(
    parameter int unsigned PERIOD_W = 23,
    parameter int unsigned WAIT_W   = 24,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  stream_open,
    synth_cmd_parser_if.master    bus,
    output logic [PERIOD_W-1:0]   period,
    output logic                  note_on,
    output logic                  note_off,
    output logic                  note_active,
    output logic                  mute,
    output logic                  busy,
    output logic [ERR_W-1:0]      err_cnt
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OP_W-1:0] OP_NOTE_ON  = 4'h1;
    localparam logic [OP_W-1:0] OP_NOTE_OFF = 4'h2;
    localparam logic [OP_W-1:0] OP_MUTE     = 4'h3;
    localparam logic [OP_W-1:0] OP_WAIT     = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   cmd;
    logic [WORD_W-1:0]   cmd_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic                note_on_nxt;
    logic                note_off_nxt;
    logic                active_nxt;
    logic                mute_nxt;
    logic [ERR_W-1:0]    err_nxt;
    logic                pop_c;
    logic                exec_go;

    logic [OP_W-1:0]     cmd_op;
    logic [PERIOD_W-1:0] cmd_period;
    logic [WAIT_W-1:0]   cmd_wait;

    assign cmd_op     = cmd[WORD_W-1 -: OP_W];
    assign cmd_period = cmd[PERIOD_W-1:0];
    assign cmd_wait   = cmd[WAIT_W-1:0];

    // Pop decision comes straight from the registered state so data lands in FETCH.
    assign pop_c          = (state == ST_IDLE) && !bus.fifo_empty && stream_open;
    assign bus.fifo_rd_en = pop_c;
    assign busy           = (state != ST_IDLE);

`ifdef SYNTH_CMD_ECHO_EN
    logic              echo_wr_q;
    logic              echo_wr_nxt;
    logic [WORD_W-1:0] echo_data_q;
    logic [WORD_W-1:0] echo_data_nxt;

    // A full readback FIFO holds the command in EXEC until there is room for its echo.
    assign exec_go        = !bus.echo_full;
    assign bus.echo_wr_en = echo_wr_q;
    assign bus.echo_data  = echo_data_q;
`else
    logic unused_echo_full;
    logic unused_cmd;

    assign exec_go          = 1'b1;
    assign unused_echo_full = bus.echo_full;
    assign unused_cmd       = ^cmd;
    assign bus.echo_wr_en   = 1'b0;
    assign bus.echo_data    = '0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            wait_cnt    <= '0;
            period      <= '0;
            note_on     <= 1'b0;
            note_off    <= 1'b0;
            note_active <= 1'b0;
            mute        <= 1'b0;
            err_cnt     <= '0;
`ifdef SYNTH_CMD_ECHO_EN
            echo_wr_q   <= 1'b0;
            echo_data_q <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cmd         <= cmd_nxt;
            wait_cnt    <= wait_nxt;
            period      <= period_nxt;
            note_on     <= note_on_nxt;
            note_off    <= note_off_nxt;
            note_active <= active_nxt;
            mute        <= mute_nxt;
            err_cnt     <= err_nxt;
`ifdef SYNTH_CMD_ECHO_EN
            echo_wr_q   <= echo_wr_nxt;
            echo_data_q <= echo_data_nxt;
`endif
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        wait_nxt     = wait_cnt;
        period_nxt   = period;
        note_on_nxt  = 1'b0;
        note_off_nxt = 1'b0;
        active_nxt   = note_active;
        mute_nxt     = mute;
        err_nxt      = err_cnt;
`ifdef SYNTH_CMD_ECHO_EN
        echo_wr_nxt   = 1'b0;
        echo_data_nxt = echo_data_q;
`endif

        if (!stream_open) begin
            // Flush: drop any in-flight command and release a sounding note.
            state_nxt = ST_IDLE;
            wait_nxt  = '0;
            if (note_active) begin
                note_off_nxt = 1'b1;
                active_nxt   = 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        state_nxt = ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    cmd_nxt   = bus.fifo_dout;
                    state_nxt = ST_EXEC;
                end

                ST_EXEC: begin
                    if (exec_go) begin
                        state_nxt = ST_IDLE;
`ifdef SYNTH_CMD_ECHO_EN
                        echo_wr_nxt   = 1'b1;
                        echo_data_nxt = cmd;
`endif
                        case (cmd_op)
                            OP_NOP: ;
                            OP_NOTE_ON, OP_NOTE_OFF: begin
                                // A zero period is a note-off; period is held for the release tail.
                                if ((cmd_op == OP_NOTE_ON) && (cmd_period != '0)) begin
                                    period_nxt  = cmd_period;
                                    note_on_nxt = 1'b1;
                                    active_nxt  = 1'b1;
                                end else if (note_active) begin
                                    note_off_nxt = 1'b1;
                                    active_nxt   = 1'b0;
                                end
                            end
                            OP_MUTE: begin
                                mute_nxt = cmd[0];
                            end
                            OP_WAIT: begin
                                if (cmd_wait != '0) begin
                                    wait_nxt  = cmd_wait;
                                    state_nxt = ST_WAIT;
                                end
                            end
                            default: begin
                                if (err_cnt != {ERR_W{1'b1}}) begin
                                    err_nxt = err_cnt + ERR_W'(1);
                                end
                            end
                        endcase
                    end
                end

                ST_WAIT: begin
                    // Counter was loaded with the full count, so WAIT lasts exactly count cycles.
                    wait_nxt = wait_cnt - WAIT_W'(1);
                    if (wait_cnt <= WAIT_W'(1)) begin
                        wait_nxt  = '0;
                        state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_synth_cmd_parser.sv
// Randomized bench for synth_cmd_parser against a transaction-timing reference model.
// Model: each popped word takes effect 3 cycles after its pop; a WAIT delays the next pop by its count.
module tb_synth_cmd_parser;
    localparam int unsigned PERIOD_W = 23;
    localparam int unsigned WAIT_W   = 24;
    localparam int unsigned ERR_W    = 8;

    logic                clk = 1'b0;
    logic                rst_b;
    logic                stream_open;
    logic [PERIOD_W-1:0] period;
    logic                note_on;
    logic                note_off;
    logic                note_active;
    logic                mute;
    logic                busy;
    logic [ERR_W-1:0]    err_cnt;

    synth_cmd_parser_if bus_if ();

    synth_cmd_parser #(
        .PERIOD_W (PERIOD_W),
        .WAIT_W   (WAIT_W),
        .ERR_W    (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .stream_open (stream_open),
        .bus         (bus_if),
        .period      (period),
        .note_on     (note_on),
        .note_off    (note_off),
        .note_active (note_active),
        .mute        (mute),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [31:0]         q[$];
    bit                  pend_valid;
    logic [31:0]         pend_w;
    int                  pend_at;
    int                  m_ready;
    int                  last_pop;
    bit                  abort_pend;
    bit                  dout_valid;
    logic [31:0]         dout_w;
    logic [PERIOD_W-1:0] exp_period;
    bit                  exp_active;
    bit                  exp_mute;
    logic [ERR_W-1:0]    exp_err;
    bit                  exp_on;
    bit                  exp_off;
    bit                  exp_echo_wr;
    logic [31:0]         exp_echo_data;

    // Observed DUT events
    int on_cyc;
    int off_cyc;
    int off_cnt;
    int rd_seen;
    int pop_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int wait_len(input logic [31:0] w);
        return (w[31:28] == 4'h4) ? int'(w[WAIT_W-1:0]) : 0;
    endfunction

    // Command semantics at the level of the command set.
    task automatic model_exec(input logic [31:0] w);
        logic [3:0]          op;
        logic [PERIOD_W-1:0] p;
        op = w[31:28];
        p  = w[PERIOD_W-1:0];
        if (op == 4'h1 && p != '0) begin
            exp_period = p;
            exp_on     = 1'b1;
            exp_active = 1'b1;
        end else if (op == 4'h1 || op == 4'h2) begin
            if (exp_active) begin
                exp_off    = 1'b1;
                exp_active = 1'b0;
            end
        end else if (op == 4'h3) begin
            exp_mute = w[0];
        end else if (op >= 4'h5) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end
`ifdef SYNTH_CMD_ECHO_EN
        exp_echo_wr   = 1'b1;
        exp_echo_data = w;
`endif
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int unsigned r;
        w = $urandom;
        r = $urandom_range(0, 9);
        case (r)
            0: w[31:28] = 4'h0;
            1, 2, 3, 8: begin
                w[31:28] = 4'h1;
                if ($urandom_range(0, 3) == 0) w[PERIOD_W-1:0] = '0;
            end
            4: w[31:28] = 4'h2;
            5: w[31:28] = 4'h3;
            6: begin
                w[31:28]       = 4'h4;
                w[WAIT_W-1:0]  = WAIT_W'($urandom_range(0, 15));
            end
            default: w[31:28] = 4'($urandom_range(5, 15));
        endcase
        return w;
    endfunction

    // One clock cycle: advance model, drive inputs, compare, then clock.
    task automatic step();
        logic [31:0] w;
        bit          exp_rd;
        bit          exp_busy;
        exp_on      = 1'b0;
        exp_off     = 1'b0;
        exp_echo_wr = 1'b0;
        if (abort_pend) begin
            abort_pend = 1'b0;
            pend_valid = 1'b0;
            m_ready    = cyc;
            if (exp_active) begin
                exp_off    = 1'b1;
                exp_active = 1'b0;
            end
        end else if (pend_valid && pend_at == cyc) begin
            pend_valid = 1'b0;
            model_exec(pend_w);
        end
        bus_if.fifo_empty = (q.size() == 0);
        bus_if.fifo_dout  = dout_valid ? dout_w : $urandom;
        dout_valid        = 1'b0;
        #1;
`ifdef SYNTH_CMD_ECHO_EN
        if (pend_valid && pend_at == cyc + 1 && bus_if.echo_full && stream_open) begin
            pend_at++;
            m_ready++;
        end
`endif
        check("period", 32'(period), 32'(exp_period));
        check("note_on", 32'(note_on), 32'(exp_on));
        check("note_off", 32'(note_off), 32'(exp_off));
        check("note_active", 32'(note_active), 32'(exp_active));
        check("mute", 32'(mute), 32'(exp_mute));
        check("err_cnt", 32'(err_cnt), 32'(exp_err));
        check("echo_wr_en", 32'(bus_if.echo_wr_en), 32'(exp_echo_wr));
        check("echo_data", bus_if.echo_data, exp_echo_data);
        exp_busy = (cyc > last_pop) && (cyc < m_ready);
        check("busy", 32'(busy), 32'(exp_busy));
        exp_rd = stream_open && (q.size() != 0) && (cyc >= m_ready);
        check("fifo_rd_en", 32'(bus_if.fifo_rd_en), 32'(exp_rd));
        if (note_on) on_cyc = cyc;
        if (note_off) begin
            off_cyc = cyc;
            off_cnt++;
        end
        if (bus_if.fifo_rd_en) rd_seen++;
        if (exp_rd) begin
            w          = q.pop_front();
            dout_valid = 1'b1;
            dout_w     = w;
            pend_valid = 1'b1;
            pend_w     = w;
            pend_at    = cyc + 3;
            last_pop   = cyc;
            pop_cyc    = cyc;
            m_ready    = cyc + 3 + wait_len(w);
        end
        if (!stream_open) abort_pend = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!(q.size() == 0 && !pend_valid && cyc >= m_ready)) begin
            if (n >= max_cyc) begin
                check(tag, 32'(1), 32'(0));
                return;
            end
            step();
            n++;
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold_low;
        int first_pop;
        rst_b             = 1'b0;
        stream_open       = 1'b1;
        bus_if.fifo_empty = 1'b1;
        bus_if.fifo_dout  = '0;
        bus_if.echo_full  = 1'b0;
        pend_valid = 1'b0; pend_w = '0; pend_at = 0; m_ready = 0; last_pop = -1;
        abort_pend = 1'b0; dout_valid = 1'b0; dout_w = '0;
        exp_period = '0; exp_active = 1'b0; exp_mute = 1'b0; exp_err = '0;
        exp_on = 1'b0; exp_off = 1'b0; exp_echo_wr = 1'b0; exp_echo_data = '0;
        on_cyc = -1; off_cyc = -1; off_cnt = 0; rd_seen = 0; pop_cyc = -1;
        hold_low = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_period", 32'(period), 32'(0));
        check("rst_note_on", 32'(note_on), 32'(0));
        check("rst_note_off", 32'(note_off), 32'(0));
        check("rst_active", 32'(note_active), 32'(0));
        check("rst_mute", 32'(mute), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err_cnt), 32'(0));
        check("rst_rd_en", 32'(bus_if.fifo_rd_en), 32'(0));
        check("rst_echo_wr", 32'(bus_if.echo_wr_en), 32'(0));
        rst_b = 1'b1;
        cyc   = 0;

        // Single NOTE_ON: effect 3 cycles after the pop.
        q.push_back(32'h1000_1234);
        run_idle(50, "timeout_note_on");
        first_pop = pop_cyc;
        check("on_latency", 32'(on_cyc - first_pop), 32'(3));
        check("on_period", 32'(period), 32'h1234);

        // NOTE_ON, WAIT 100, NOTE_OFF: note_off lands 100 + 2*3 cycles after note_on.
        q.push_back(32'h1000_1234);
        q.push_back(32'h4000_0064);
        q.push_back(32'h2000_0000);
        run_idle(400, "timeout_wait");
        check("wait_gap", 32'(off_cyc - on_cyc), 32'(106));
        check("wait_period_held", 32'(period), 32'h1234);

        // Zero-period NOTE_ON acts as NOTE_OFF.
        off_cnt = 0;
        q.push_back(32'h1000_0000);
        q.push_back(32'h1000_0400);
        q.push_back(32'h1000_0000);
        run_idle(100, "timeout_zero_period");
        check("zero_period_offs", 32'(off_cnt), 32'(1));
        check("zero_period_held", 32'(period), 32'h400);

        // Mute on, then bad opcodes saturate the error counter.
        q.push_back(32'h3000_0001);
        for (int i = 0; i < 260; i++) q.push_back(32'hF000_0000);
        run_idle(2000, "timeout_bad_ops");
        check("err_saturated", 32'(err_cnt), 32'hFF);
        check("bad_ops_mute", 32'(mute), 32'(1));
        check("bad_ops_period", 32'(period), 32'h400);

        // Abort during a long WAIT with a note sounding.
        q.push_back(32'h1000_0100);
        q.push_back(32'h4000_03E8);
        q.push_back(32'h1000_0200);
        q.push_back(32'h1000_0300);
        run(30);
        stream_open = 1'b0;
        off_cnt     = 0;
        rd_seen     = 0;
        run(2);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_active", 32'(note_active), 32'(0));
        run(8);
        check("abort_offs", 32'(off_cnt), 32'(1));
        check("abort_pops", 32'(rd_seen), 32'(0));
        stream_open = 1'b1;
        run_idle(100, "timeout_resume");
        check("resume_pops", 32'(rd_seen), 32'(2));
        check("resume_period", 32'(period), 32'h300);

`ifdef SYNTH_CMD_ECHO_EN
        // Readback full stalls EXEC; release executes and echoes together.
        q.push_back(32'h3000_0000);
        run_idle(50, "timeout_unmute");
        bus_if.echo_full = 1'b1;
        q.push_back(32'h3000_0001);
        run(10);
        check("echo_stall_mute", 32'(mute), 32'(0));
        check("echo_stall_busy", 32'(busy), 32'(1));
        bus_if.echo_full = 1'b0;
        run_idle(50, "timeout_echo_release");
        check("echo_release_mute", 32'(mute), 32'(1));
        check("echo_last_data", bus_if.echo_data, 32'h3000_0001);
`endif

        // Random traffic with occasional stream drops and readback back-pressure.
        for (int i = 0; i < 3000; i++) begin
            if (q.size() < 8 && $urandom_range(0, 2) == 0) q.push_back(rand_word());
            if (hold_low > 0) begin
                stream_open = 1'b0;
                hold_low--;
            end else begin
                stream_open = 1'b1;
                if ($urandom_range(0, 99) == 0) hold_low = int'($urandom_range(1, 3));
            end
            bus_if.echo_full = ($urandom_range(0, 3) == 0);
            step();
        end
        stream_open      = 1'b1;
        bus_if.echo_full = 1'b0;
        run_idle(5000, "timeout_random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/synth_cmd_parser.md
Name: synth_cmd_parser

Overview:
- Sits between the CPU-to-FPGA 32-bit write stream FIFO and the synth voice (square generator plus envelope generator). All on the clk_calc domain.
- Pops 32-bit command words from the FIFO and decodes them into a held tone period, single-cycle note_on/note_off pulses and a mute flag.
- A WAIT opcode lets software schedule timed note sequences without CPU timing jitter.
- Replaces the ad-hoc "period changed" edge detector currently driving the envelope generator.

Parameters:
- PERIOD_W, 23: width of the tone period field and of the `period` output.
- WAIT_W, 24: width of the WAIT cycle count field and of the internal wait counter.
- ERR_W, 8: width of the saturating bad-opcode counter.

Ports:
- clk  input  1  processing clock (clk_calc domain).
- rst_b  input  1  asynchronous active-low reset.
- stream_open  input  1  command stream open; low = flush/abort.
- fifo_empty  input  1  command FIFO empty.
- fifo_rd_en  output  1  FIFO pop; data valid the cycle after assertion.
- fifo_dout  input  32  command word.
- period  output  PERIOD_W  current tone period to the square generator.
- note_on  output  1  one-cycle pulse to the envelope generator.
- note_off  output  1  one-cycle pulse to the envelope generator.
- note_active  output  1  a note is sounding.
- mute  output  1  mute request to the audio path.
- busy  output  1  state != IDLE.
- err_cnt  output  ERR_W  count of bad opcodes, saturating.
- echo_wr_en  output  1  see Optional Feature.
- echo_data  output  32  see Optional Feature.
- echo_full  input  1  see Optional Feature.

Behaviour:
- Reset (rst_b low, asynchronous): state=IDLE. Outputs period=0, note_on=0, note_off=0, note_active=0, mute=0, busy=0, err_cnt=0, fifo_rd_en=0, echo_wr_en=0. Wait counter=0.
- Command word format: opcode [31:28], operands in the low bits.
  - 0x0 NOP.
  - 0x1 NOTE_ON, period [PERIOD_W-1:0].
  - 0x2 NOTE_OFF.
  - 0x3 MUTE, value [0].
  - 0x4 WAIT, count [WAIT_W-1:0].
  - Any other opcode is bad.
- State IDLE:
  - fifo_rd_en = !fifo_empty && stream_open. This is combinational from the registered state.
  - If popped, go to FETCH.
- State FETCH: register fifo_dout into cmd; go to EXEC.
- State EXEC: apply cmd. All output effects are registered and visible the cycle after EXEC.
  - NOTE_ON with period!=0: period<=field, note_on pulse, note_active<=1.
    - A NOTE_ON while already active retriggers: new period plus a new note_on pulse, with no note_off.
  - NOTE_ON with period==0: treated exactly as NOTE_OFF.
  - NOTE_OFF:
    - If note_active: note_off pulse, note_active<=0.
    - period is held, so the release tail keeps its pitch.
    - If not active, no pulse.
  - MUTE: mute<=value[0].
  - WAIT:
    - count==0 behaves as NOP.
    - Otherwise load counter=count and go to WAIT.
  - Bad opcode: err_cnt<=err_cnt+1, saturating at all-ones. No other effect.
  - All other cases go to IDLE.
- State WAIT:
  - Counter decrements each cycle; at counter==1 go to IDLE.
  - Total cycles spent in WAIT = count exactly.
- Throughput: at most one command per 3 cycles (IDLE→FETCH→EXEC). A WAIT adds count cycles on top.
- note_on and note_off are never high in the same cycle.
- stream_open low (synchronous, any state except reset):
  - Abort to IDLE next cycle; no further pops.
  - A cmd in FETCH/EXEC is discarded unexecuted.
  - If note_active: one note_off pulse, note_active<=0.
  - mute, period and err_cnt are retained.
- fifo_empty in IDLE: stay in IDLE, rd_en=0. fifo_rd_en is never asserted while fifo_empty=1.
- busy = (state!=IDLE).

Optional Feature:
- Macro: SYNTH_CMD_ECHO_EN.
- Defined:
  - In EXEC, echo_data<=cmd and echo_wr_en pulses for 1 cycle, for every executed word including bad ones. This feeds the FPGA-to-CPU read FIFO for readback.
  - If echo_full=1 in EXEC, stay in EXEC with no state effects until echo_full=0. The command is then executed and echoed in the same cycle.
  - A stream_open drop still aborts, without echoing.
- Not defined: echo_wr_en tied to 0, echo_data tied to 0, echo_full ignored. Timing is otherwise identical.

Test Plan:
- Reset then push 0x1000_1234 → fifo_rd_en 1 cycle; 3 cycles after the pop, period=0x1234, note_on=1 for one cycle, note_active=1.
- Push 0x1000_1234, 0x4000_0064, 0x2000_0000 → note_off pulse exactly 100 cycles plus FSM overhead after note_on (measure: WAIT occupies 100 cycles); period stays 0x1234 after note_off.
- Push 0x1000_0000 with no note active → no pulse. Push 0x1000_0400 then 0x1000_0000 → single note_off pulse, period stays 0x400.
- Push 0xF000_0000 260 times → err_cnt saturates at 0xFF; period, mute and note_active are unchanged.
- During WAIT of 1000 with a note active, drop stream_open → IDLE next cycle, one note_off pulse, no further pops while FIFO non-empty; raising stream_open resumes popping.
- With SYNTH_CMD_ECHO_EN, echo_full=1, push 0x3000_0001 → parser holds in EXEC with mute=0; release echo_full → mute=1 and echo_wr_en with echo_data=0x3000_0001 in the same cycle.
